// File: rtl/cache_tag_ctrl_pkg.sv
// ============================================================================
// Module      : cache_types (package)
// Description : Command encodings and default geometry shared by the cache
//               tag controller and its replacement helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_types;

    localparam int CACHE_WAYS      = 4;
    localparam int CACHE_SETS      = 8;
    localparam int CACHE_TAG_WIDTH = 9;
    localparam int WAY_W           = $clog2(CACHE_WAYS);
    localparam int SET_W           = $clog2(CACHE_SETS);

    typedef enum logic [1:0] {
        CMD_LOOKUP_READ  = 2'b00,
        CMD_LOOKUP_WRITE = 2'b01,
        CMD_FILL         = 2'b10,
        CMD_INVALIDATE   = 2'b11
    } cache_cmd_t;

endpackage

`default_nettype wire

// File: rtl/cache_tag_ctrl_plru.sv
// ============================================================================
// Module      : plru_tree
// Description : Combinational tree pseudo-LRU: victim walk and touch update
//               for one set. Used only when CACHE_PLRU_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         state_i,
    input  logic [$clog2(WAYS)-1:0] touch_i,
    output logic [WAYS-2:0]         next_o,
    output logic [$clog2(WAYS)-1:0] victim_o
);

    localparam int c_LEVELS = $clog2(WAYS);

    int   node;
    logic dir;

    // A node bit of 0 steers toward the lower-index half; touching a way
    // flips every node on its path to steer away from it.
    always_comb begin
        next_o   = state_i;
        victim_o = '0;
        node     = 0;
        dir      = 1'b0;
        for (int l = 0; l < c_LEVELS; l++) begin
            victim_o[c_LEVELS-1-l] = state_i[node];
            node = 2 * node + 1 + int'(state_i[node]);
        end
        node = 0;
        for (int l = 0; l < c_LEVELS; l++) begin
            dir          = touch_i[c_LEVELS-1-l];
            next_o[node] = ~dir;
            node         = 2 * node + 1 + int'(dir);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_tag_ctrl.sv
// ============================================================================
// Module      : cache_tag_ctrl
// Description : N-way set-associative tag/valid/dirty store with registered
//               hit/victim report. Define CACHE_PLRU_EN for tree PLRU,
//               otherwise a per-set round-robin pointer is used.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_tag_ctrl
    import cache_types::*;
#(
    parameter int WAYS      = CACHE_WAYS,
    parameter int SETS      = CACHE_SETS,
    parameter int TAG_WIDTH = CACHE_TAG_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd,
    input  logic [$clog2(SETS)-1:0] cmd_set,
    input  logic [TAG_WIDTH-1:0]    cmd_tag,
    input  logic [$clog2(WAYS)-1:0] cmd_way,
    output logic                    rsp_valid,
    output logic                    rsp_hit,
    output logic [$clog2(WAYS)-1:0] rsp_way,
    output logic [$clog2(WAYS)-1:0] rsp_victim_way,
    output logic                    rsp_victim_valid,
    output logic                    rsp_victim_dirty,
    output logic [TAG_WIDTH-1:0]    rsp_victim_tag
);

    localparam int c_WAY_W = $clog2(WAYS);

    logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];

    logic                 rsp_valid_q;
    logic                 rsp_hit_q;
    logic [c_WAY_W-1:0]   rsp_way_q;
    logic [c_WAY_W-1:0]   rsp_victim_way_q;
    logic                 rsp_victim_valid_q;
    logic                 rsp_victim_dirty_q;
    logic [TAG_WIDTH-1:0] rsp_victim_tag_q;

    cache_cmd_t           w_cmd;
    logic                 w_hit;
    logic [c_WAY_W-1:0]   w_hit_way;
    logic                 w_inv_found;
    logic [c_WAY_W-1:0]   w_inv_way;
    logic [c_WAY_W-1:0]   w_repl_way;
    logic [c_WAY_W-1:0]   w_victim_way;
    logic                 w_victim_valid;

    assign w_cmd = cache_cmd_t'(cmd);

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[cmd_set][w] && (tag_q[cmd_set][w] == cmd_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_WAY_W'(w);
            end
            if (!valid_q[cmd_set][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_WAY_W'(w);
            end
        end
    end

    assign w_victim_way   = w_inv_found ? w_inv_way : w_repl_way;
    assign w_victim_valid = valid_q[cmd_set][w_victim_way];

`ifdef CACHE_PLRU_EN
    logic [WAYS-2:0]    plru_q [SETS];
    logic [WAYS-2:0]    w_plru_d;
    logic [c_WAY_W-1:0] w_touch_way;
    logic               w_touch;

    assign w_touch_way = (w_cmd == CMD_FILL) ? cmd_way : w_hit_way;
    assign w_touch     = (w_cmd == CMD_FILL) ||
                         (w_hit && ((w_cmd == CMD_LOOKUP_READ) || (w_cmd == CMD_LOOKUP_WRITE)));

    plru_tree #(
        .WAYS (WAYS)
    ) u_plru_tree (
        .state_i  (plru_q[cmd_set]),
        .touch_i  (w_touch_way),
        .next_o   (w_plru_d),
        .victim_o (w_repl_way)
    );
`else
    logic [c_WAY_W-1:0] rr_q [SETS];

    assign w_repl_way = rr_q[cmd_set];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
`ifdef CACHE_PLRU_EN
                plru_q[s]  <= '0;
`else
                rr_q[s]    <= '0;
`endif
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w] <= '0;
                end
            end
            rsp_valid_q        <= 1'b0;
            rsp_hit_q          <= 1'b0;
            rsp_way_q          <= '0;
            rsp_victim_way_q   <= '0;
            rsp_victim_valid_q <= 1'b0;
            rsp_victim_dirty_q <= 1'b0;
            rsp_victim_tag_q   <= '0;
        end else begin
            rsp_valid_q <= cmd_valid;
            if (cmd_valid) begin
                rsp_hit_q          <= w_hit;
                rsp_way_q          <= w_hit_way;
                rsp_victim_way_q   <= w_victim_way;
                rsp_victim_valid_q <= w_victim_valid;
                rsp_victim_dirty_q <= w_victim_valid && dirty_q[cmd_set][w_victim_way];
                rsp_victim_tag_q   <= tag_q[cmd_set][w_victim_way];
                case (w_cmd)
                    CMD_LOOKUP_WRITE: begin
                        if (w_hit) begin
                            dirty_q[cmd_set][w_hit_way] <= 1'b1;
                        end
                    end
                    CMD_FILL: begin
                        tag_q[cmd_set][cmd_way]   <= cmd_tag;
                        valid_q[cmd_set][cmd_way] <= 1'b1;
                        dirty_q[cmd_set][cmd_way] <= 1'b0;
`ifndef CACHE_PLRU_EN
                        rr_q[cmd_set] <= rr_q[cmd_set] + c_WAY_W'(1);
`endif
                    end
                    CMD_INVALIDATE: begin
                        if (w_hit) begin
                            valid_q[cmd_set][w_hit_way] <= 1'b0;
                            dirty_q[cmd_set][w_hit_way] <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
`ifdef CACHE_PLRU_EN
                if (w_touch) begin
                    plru_q[cmd_set] <= w_plru_d;
                end
`endif
            end
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_hit          = rsp_hit_q;
    assign rsp_way          = rsp_way_q;
    assign rsp_victim_way   = rsp_victim_way_q;
    assign rsp_victim_valid = rsp_victim_valid_q;
    assign rsp_victim_dirty = rsp_victim_dirty_q;
    assign rsp_victim_tag   = rsp_victim_tag_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_tag_ctrl.sv
// ============================================================================
// Module      : tb_cache_tag_ctrl
// Description : Directed vector bench for cache_tag_ctrl (WAYS=4, SETS=8,
//               TAG_WIDTH=9). Expectations follow CACHE_PLRU_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_tag_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [2:0] cmd_set;
    logic [8:0] cmd_tag;
    logic [1:0] cmd_way;
    logic       rsp_valid;
    logic       rsp_hit;
    logic [1:0] rsp_way;
    logic [1:0] rsp_victim_way;
    logic       rsp_victim_valid;
    logic       rsp_victim_dirty;
    logic [8:0] rsp_victim_tag;

    int total;
    int bad;

    localparam logic [1:0] c_LR  = 2'b00;
    localparam logic [1:0] c_LW  = 2'b01;
    localparam logic [1:0] c_FL  = 2'b10;
    localparam logic [1:0] c_INV = 2'b11;

    cache_tag_ctrl #(
        .WAYS      (4),
        .SETS      (8),
        .TAG_WIDTH (9)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd              (cmd),
        .cmd_set          (cmd_set),
        .cmd_tag          (cmd_tag),
        .cmd_way          (cmd_way),
        .rsp_valid        (rsp_valid),
        .rsp_hit          (rsp_hit),
        .rsp_way          (rsp_way),
        .rsp_victim_way   (rsp_victim_way),
        .rsp_victim_valid (rsp_victim_valid),
        .rsp_victim_dirty (rsp_victim_dirty),
        .rsp_victim_tag   (rsp_victim_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] op;
        logic [8:0] tag;
        logic [1:0] way;
        logic       hit;
        logic [1:0] hway;
        logic [1:0] p_vway;
        logic [8:0] p_vtag;
        logic       p_vdirty;
        logic [1:0] r_vway;
        logic [8:0] r_vtag;
        logic       r_vdirty;
        logic       vvalid;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one command on the falling edge; response is sampled just after
    // the next rising edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] s,
                         input logic [8:0] t, input logic [1:0] w);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = op;
        cmd_set   = s;
        cmd_tag   = t;
        cmd_way   = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] ev_way;
        logic [8:0] ev_tag;
        logic       ev_dirty;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        cmd_set   = 3'd3;
        cmd_tag   = '0;
        cmd_way   = '0;

        //            op     tag    way   hit  hway  plru: vway vtag   vd   rr: vway vtag   vd   vvalid
        vecs[0]  = '{c_FL,  9'h10, 2'd0, 1'b0, 2'd0, 2'd0, 9'h000, 1'b0, 2'd0, 9'h000, 1'b0, 1'b0};
        vecs[1]  = '{c_FL,  9'h11, 2'd1, 1'b0, 2'd0, 2'd1, 9'h000, 1'b0, 2'd1, 9'h000, 1'b0, 1'b0};
        vecs[2]  = '{c_FL,  9'h12, 2'd2, 1'b0, 2'd0, 2'd2, 9'h000, 1'b0, 2'd2, 9'h000, 1'b0, 1'b0};
        vecs[3]  = '{c_FL,  9'h13, 2'd3, 1'b0, 2'd0, 2'd3, 9'h000, 1'b0, 2'd3, 9'h000, 1'b0, 1'b0};
        vecs[4]  = '{c_LW,  9'h10, 2'd0, 1'b1, 2'd0, 2'd0, 9'h010, 1'b0, 2'd0, 9'h010, 1'b0, 1'b1};
        vecs[5]  = '{c_LW,  9'h12, 2'd0, 1'b1, 2'd2, 2'd2, 9'h012, 1'b0, 2'd0, 9'h010, 1'b1, 1'b1};
        vecs[6]  = '{c_LR,  9'h55, 2'd0, 1'b0, 2'd0, 2'd1, 9'h011, 1'b0, 2'd0, 9'h010, 1'b1, 1'b1};
        vecs[7]  = '{c_LR,  9'h11, 2'd0, 1'b1, 2'd1, 2'd1, 9'h011, 1'b0, 2'd0, 9'h010, 1'b1, 1'b1};
        vecs[8]  = '{c_LR,  9'h13, 2'd0, 1'b1, 2'd3, 2'd3, 9'h013, 1'b0, 2'd0, 9'h010, 1'b1, 1'b1};
        vecs[9]  = '{c_LR,  9'h55, 2'd0, 1'b0, 2'd0, 2'd0, 9'h010, 1'b1, 2'd0, 9'h010, 1'b1, 1'b1};
        vecs[10] = '{c_INV, 9'h12, 2'd0, 1'b1, 2'd2, 2'd0, 9'h010, 1'b1, 2'd0, 9'h010, 1'b1, 1'b1};
        vecs[11] = '{c_LR,  9'h12, 2'd0, 1'b0, 2'd0, 2'd2, 9'h000, 1'b0, 2'd2, 9'h000, 1'b0, 1'b0};

        do_reset();
        @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_hit", 32'(rsp_hit), 32'd0);
        chk("reset_rsp_victim", 32'({rsp_way, rsp_victim_way, rsp_victim_valid,
                                     rsp_victim_dirty, rsp_victim_tag}), 32'd0);

        // Cold lookup
        issue(c_LR, 3'd3, 9'h1A5, 2'd0);
        chk("cold_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("cold_hit", 32'(rsp_hit), 32'd0);
        chk("cold_victim_way", 32'(rsp_victim_way), 32'd0);
        chk("cold_victim_valid", 32'(rsp_victim_valid), 32'd0);
        chk("cold_victim_dirty", 32'(rsp_victim_dirty), 32'd0);

        // Fill then immediate lookup: back-to-back visibility
        issue(c_FL, 3'd3, 9'h1A5, 2'd0);
        chk("fill_prefill_hit", 32'(rsp_hit), 32'd0);
        issue(c_LR, 3'd3, 9'h1A5, 2'd0);
        chk("b2b_hit", 32'(rsp_hit), 32'd1);
        chk("b2b_way", 32'(rsp_way), 32'd0);
        chk("b2b_victim_way", 32'(rsp_victim_way), 32'd1);
        idle_cycle();
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_hold_hit", 32'(rsp_hit), 32'd1);
        issue(c_LR, 3'd2, 9'h1A5, 2'd0);
        chk("other_set_hit", 32'(rsp_hit), 32'd0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, 3'd3, vecs[i].tag, vecs[i].way);
`ifdef CACHE_PLRU_EN
            ev_way   = vecs[i].p_vway;
            ev_tag   = vecs[i].p_vtag;
            ev_dirty = vecs[i].p_vdirty;
`else
            ev_way   = vecs[i].r_vway;
            ev_tag   = vecs[i].r_vtag;
            ev_dirty = vecs[i].r_vdirty;
`endif
            chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d_hit", i), 32'(rsp_hit), 32'(vecs[i].hit));
            chk($sformatf("vec%0d_way", i), 32'(rsp_way), 32'(vecs[i].hway));
            chk($sformatf("vec%0d_vway", i), 32'(rsp_victim_way), 32'(ev_way));
            chk($sformatf("vec%0d_vvalid", i), 32'(rsp_victim_valid), 32'(vecs[i].vvalid));
            chk($sformatf("vec%0d_vdirty", i), 32'(rsp_victim_dirty), 32'(ev_dirty));
            if (vecs[i].vvalid) begin
                chk($sformatf("vec%0d_vtag", i), 32'(rsp_victim_tag), 32'(ev_tag));
            end
        end

        // Reset together with a command drops it
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd       = c_FL;
        cmd_set   = 3'd3;
        cmd_tag   = 9'h77;
        cmd_way   = 2'd1;
        @(posedge clk);
        #1;
        chk("rstcmd_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rstcmd_next_rsp_valid", 32'(rsp_valid), 32'd0);
        issue(c_LR, 3'd3, 9'h77, 2'd0);
        chk("rstcmd_lookup_hit", 32'(rsp_hit), 32'd0);
        chk("rstcmd_victim_way", 32'(rsp_victim_way), 32'd0);
        chk("rstcmd_victim_valid", 32'(rsp_victim_valid), 32'd0);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
